// File: rtl/sdf_pair_gen_pkg.sv
// ============================================================================
// Module  : sdf_pair_gen_pkg
// Brief   : Shared NTT parameters and helpers for the SDF pair generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdf_pair_gen_pkg;

    localparam int DEF_LOGQ  = 64;
    localparam int DEF_LOGN  = 12;
    localparam int DEF_STAGE = 0;

    // phase bit of the element counter: first half of a 2D-block fills, second half pairs
    typedef enum logic {
        PH_FILL = 1'b0,
        PH_PAIR = 1'b1
    } phase_e;

    function automatic int d_log_of(input int logn, input int stage);
        return logn - 1 - stage;
    endfunction

    function automatic int blk_shift_of(input int logn, input int stage);
        return logn - stage;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdf_pair_gen_if.sv
// ============================================================================
// Module  : sdf_pair_gen_if
// Brief   : Coefficient stream in / butterfly pair out bundle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdf_pair_gen_if #(
    parameter int LOGQ = 64,
    parameter int LOGN = 12
) ();

    logic            intt;
    logic [LOGQ-1:0] din;
    logic            din_valid;
    logic [LOGQ-1:0] pair_a;
    logic [LOGQ-1:0] pair_b;
    logic [LOGN-1:0] tw_addr;
    logic            pair_valid;
    logic            pair_last;
    logic            pair_intt;

    modport master (
        output intt, din, din_valid,
        input  pair_a, pair_b, tw_addr, pair_valid, pair_last, pair_intt
    );

    modport slave (
        input  intt, din, din_valid,
        output pair_a, pair_b, tw_addr, pair_valid, pair_last, pair_intt
    );

endinterface

`default_nettype wire

// File: rtl/sdf_delay_ram.sv
// ============================================================================
// Module  : sdf_delay_ram
// Brief   : Simple dual-port delay RAM, 1-cycle registered read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdf_delay_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1,
    parameter int AW    = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             wr_en,
    input  wire logic [AW-1:0]    wr_addr,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic             rd_en,
    input  wire logic [AW-1:0]    rd_addr,
    output logic      [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_rd_data;

    generate
        if (DEPTH == 1) begin : g_reg
            logic [WIDTH-1:0] r_mem;
            logic             w_unused_addr;

            assign w_unused_addr = ^{wr_addr, rd_addr};

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_mem <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (rd_en) begin
                    r_rd_data <= r_mem;
                end
            end
        end else begin : g_mem
            logic [WIDTH-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    r_mem[wr_addr] <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (rd_en) begin
                    r_rd_data <= r_mem[rd_addr];
                end
            end
        end
    endgenerate

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/sdf_pair_gen.sv
// ============================================================================
// Module  : sdf_pair_gen
// Brief   : Radix-2 SDF DIT NTT stage feed: pairs element k with k+D.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdf_pair_gen
    import sdf_pair_gen_pkg::*;
#(
    parameter int LOGQ  = DEF_LOGQ,
    parameter int LOGN  = DEF_LOGN,
    parameter int STAGE = DEF_STAGE
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sdf_pair_gen_if.slave bus
);

    localparam int            c_D_LOG     = d_log_of(LOGN, STAGE);
    localparam int            c_D         = 1 << c_D_LOG;
    localparam int            c_BLK_SHIFT = blk_shift_of(LOGN, STAGE);
    localparam int            c_AW        = (c_D_LOG > 0) ? c_D_LOG : 1;
    localparam logic [LOGN-1:0] c_LAST    = {LOGN{1'b1}};
    localparam logic [LOGN-1:0] c_TW_BASE = LOGN'(1) << STAGE;

    logic [LOGN-1:0] r_cnt;
    logic [LOGQ-1:0] r_pair_b;
    logic [LOGN-1:0] r_tw_addr;
    logic            r_pair_valid;
    logic            r_pair_last;
    logic            r_pair_intt;
    logic            r_intt_poly;

    phase_e          w_phase;
    logic [c_AW-1:0] w_ptr;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [LOGN-1:0] w_tw;
    logic [LOGQ-1:0] w_ram_rd;

    assign w_phase = phase_e'(r_cnt[c_D_LOG]);

    generate
        if (c_D_LOG > 0) begin : g_ptr_wide
            assign w_ptr = r_cnt[c_AW-1:0];
        end else begin : g_ptr_zero
            assign w_ptr = '0;
        end
    endgenerate

    assign w_wr_en = bus.din_valid && (w_phase == PH_FILL);
    assign w_rd_en = bus.din_valid && (w_phase == PH_PAIR);

    // Block index shifts out entirely at stage 0, leaving the base address
    assign w_tw = c_TW_BASE | (r_cnt >> c_BLK_SHIFT);

    sdf_delay_ram #(
        .WIDTH (LOGQ),
        .DEPTH (c_D),
        .AW    (c_AW)
    ) u_delay_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (w_ptr),
        .wr_data (bus.din),
        .rd_en   (w_rd_en),
        .rd_addr (w_ptr),
        .rd_data (w_ram_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_pair_b     <= '0;
            r_tw_addr    <= '0;
            r_pair_valid <= 1'b0;
            r_pair_last  <= 1'b0;
            r_pair_intt  <= 1'b0;
            r_intt_poly  <= 1'b0;
        end else begin
            r_pair_valid <= w_rd_en;
            if (bus.din_valid) begin
                r_cnt <= r_cnt + LOGN'(1);
            end
            if (bus.din_valid && (r_cnt == '0)) begin
                r_intt_poly <= bus.intt;
            end
            // Pair outputs capture on the b accept; the RAM read lands in the same cycle
            if (w_rd_en) begin
                r_pair_b    <= bus.din;
                r_tw_addr   <= w_tw;
                r_pair_last <= (r_cnt == c_LAST);
                r_pair_intt <= r_intt_poly;
            end
        end
    end

    assign bus.pair_a     = w_ram_rd;
    assign bus.pair_b     = r_pair_b;
    assign bus.tw_addr    = r_tw_addr;
    assign bus.pair_valid = r_pair_valid;
    assign bus.pair_last  = r_pair_last;
    assign bus.pair_intt  = r_pair_intt;

endmodule

`default_nettype wire
